// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the out-of-order core.
// This file holds the physical register ID type used by rename and the ROB.
// It also holds the free-list sizing constants and pointer type.
//   free_list_t      - physical register ID (8 bits)
//   FREE_LIST_DEPTH  - free-list entries (NUM_PHYS - NUM_ARCH at defaults)
//   FREE_LIST_PW     - free-list pointer width, including the wrap bit
//   free_list_ptr_t  - free-list pointer (index bits plus wrap bit)
package rv32i_types;

  typedef logic [7:0] free_list_t;

  localparam int FREE_LIST_DEPTH = 32;
  localparam int FREE_LIST_PW    = $clog2(FREE_LIST_DEPTH) + 1;

  typedef logic [FREE_LIST_PW-1:0] free_list_ptr_t;

endpackage

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register IDs for the rename stage.
//
// Rename pops from the speculative head. ROB commit pushes superseded
// registers at the tail. A second head (arch_head) advances only on commit,
// so a flush can hand back every speculatively allocated register in one cycle.
//
// Ports:
//   clk, rst_n    - clock and asynchronous active-low reset
//   alloc_req     - rename wants one register this cycle
//   alloc_valid   - list non-empty and not flushing
//   alloc_preg    - register at the speculative head (fall-through read)
//   commit_valid  - committing instruction had allocated a register
//   free_valid    - committing instruction frees free_preg
//   free_preg     - register being returned to the list
//   flush         - mispredict / exception recovery
//   free_count    - occupancy, tail - head
//   err           - sticky overflow / architectural-head overrun flag
module free_list
  import rv32i_types::*;
#(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int DEPTH    = NUM_PHYS - NUM_ARCH,
  parameter int PW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_req,
  output logic          alloc_valid,
  output free_list_t    alloc_preg,
  input  logic          commit_valid,
  input  logic          free_valid,
  input  free_list_t    free_preg,
  input  logic          flush,
  output logic [PW-1:0] free_count,
  output logic          err
);

  // DEPTH is a power of two, so it is exactly representable in PW bits.
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  free_list_t    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] arch_head;
  logic [PW-1:0] tail;

  logic          full;
  logic          empty;
  logic          alloc_fire;
  logic          free_fire;
  logic          free_drop;
  logic          commit_overrun;
  logic          commit_fire;
  logic [PW-1:0] arch_head_next;
  logic [PW-1:0] head_next;

  // The head read has no bypass. A register written this cycle at the tail
  // only becomes visible once the write has landed in mem.
  assign alloc_preg = mem[head[PW-2:0]];

  // Decide which operations take effect this cycle.
  // A free at full is still accepted when an allocation frees a slot in the
  // same cycle. A flush suppresses allocation, so a free at full during a
  // flush is dropped.
  // A commit while arch_head has already caught up with head would point the
  // architectural head at an unallocated register. It is refused and flagged.
  always_comb begin
    free_count     = tail - head;
    full           = (free_count == DEPTH_PTR);
    empty          = (free_count == '0);
    alloc_valid    = !empty && !flush;
    alloc_fire     = alloc_req && alloc_valid;
    free_fire      = free_valid && (!full || alloc_fire);
    free_drop      = free_valid && !free_fire;
    commit_overrun = commit_valid && (arch_head == head);
    commit_fire    = commit_valid && !commit_overrun;

    arch_head_next = arch_head;
    if (commit_fire) begin
      arch_head_next = arch_head + PTR_ONE;
    end

    // Flush restores the speculative head from the post-commit arch_head.
    head_next = head;
    if (flush) begin
      head_next = arch_head_next;
    end else if (alloc_fire) begin
      head_next = head + PTR_ONE;
    end
  end

  // Pointer, storage and error state.
  // Reset loads the image of registers NUM_ARCH..NUM_PHYS-1. The tail starts
  // one full lap ahead of the head, so the list resets full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      arch_head <= '0;
      tail      <= DEPTH_PTR;
      err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= free_list_t'(NUM_ARCH + i);
      end
    end else begin
      head      <= head_next;
      arch_head <= arch_head_next;
      if (free_fire) begin
        mem[tail[PW-2:0]] <= free_preg;
        tail              <= tail + PTR_ONE;
      end
      if (free_drop || commit_overrun) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list.
// Stimulus drives one cycle of inputs and queues the outputs it expects for
// that cycle. A monitor pops one expectation at each falling edge and
// compares it against the DUT.
module tb_free_list;

  localparam logic [3:0] M_V   = 4'b0001;
  localparam logic [3:0] M_P   = 4'b0010;
  localparam logic [3:0] M_C   = 4'b0100;
  localparam logic [3:0] M_E   = 4'b1000;
  localparam logic [3:0] M_ALL = 4'b1111;

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic       exp_valid;
    logic [7:0] exp_preg;
    logic [5:0] exp_count;
    logic       exp_err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_req;
  logic       alloc_valid;
  logic [7:0] alloc_preg;
  logic       commit_valid;
  logic       free_valid;
  logic [7:0] free_preg;
  logic       flush;
  logic [5:0] free_count;
  logic       err;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_preg   (alloc_preg),
    .commit_valid (commit_valid),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .flush        (flush),
    .free_count   (free_count),
    .err          (err)
  );

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic req, input logic cv, input logic fv,
                               input logic [7:0] fp, input logic fl);
    @(posedge clk);
    #1;
    alloc_req    = req;
    commit_valid = cv;
    free_valid   = fv;
    free_preg    = fp;
    flush        = fl;
  endtask

  task automatic pushExp(input string name, input logic [3:0] mask,
                         input logic v, input logic [7:0] p,
                         input logic [5:0] c, input logic e);
    exp_t x;
    x.name      = name;
    x.mask      = mask;
    x.exp_valid = v;
    x.exp_preg  = p;
    x.exp_count = c;
    x.exp_err   = e;
    sb.push_back(x);
  endtask

  task automatic checkOutput(input exp_t x);
    if (x.mask[0]) begin
      compared++;
      if (alloc_valid !== x.exp_valid) begin
        mismatched++;
        $display("[TB] FAIL %s.alloc_valid actual=%0d required=%0d", x.name, alloc_valid, x.exp_valid);
      end
    end
    if (x.mask[1]) begin
      compared++;
      if (alloc_preg !== x.exp_preg) begin
        mismatched++;
        $display("[TB] FAIL %s.alloc_preg actual=%0d required=%0d", x.name, alloc_preg, x.exp_preg);
      end
    end
    if (x.mask[2]) begin
      compared++;
      if (free_count !== x.exp_count) begin
        mismatched++;
        $display("[TB] FAIL %s.free_count actual=%0d required=%0d", x.name, free_count, x.exp_count);
      end
    end
    if (x.mask[3]) begin
      compared++;
      if (err !== x.exp_err) begin
        mismatched++;
        $display("[TB] FAIL %s.err actual=%0d required=%0d", x.name, err, x.exp_err);
      end
    end
  endtask

  // Assert reset mid-cycle, check the reset image while held and just after
  // release (before the next rising edge).
  task automatic resetDut(input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b0;
    pushExp({name, "_held"}, M_ALL, 1'b1, 8'd32, 6'd32, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushExp({name, "_released"}, M_ALL, 1'b1, 8'd32, 6'd32, 1'b0);
  endtask

  // Monitor: one expectation per falling edge, whenever one is queued.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checkOutput(x);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    alloc_req    = 1'b0;
    commit_valid = 1'b0;
    free_valid   = 1'b0;
    free_preg    = 8'd0;
    flush        = 1'b0;

    // Drain the whole list from reset, then hit empty.
    resetDut("rst");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      pushExp("drain", M_ALL, 1'b1, 8'(32 + i), 6'(32 - i), 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    pushExp("empty", M_V | M_C | M_E, 1'b0, 8'd0, 6'd0, 1'b0);

    // Free into an empty list while requesting: no bypass, visible next cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd40, 1'b0);
    pushExp("free_empty", M_V | M_C | M_E, 1'b0, 8'd0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    pushExp("free_visible", M_ALL, 1'b1, 8'd40, 6'd1, 1'b0);

    // Free at full with no allocation: dropped and flagged.
    resetDut("rst_ovf");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd50, 1'b0);
    pushExp("ovf_cycle", M_ALL, 1'b1, 8'd32, 6'd32, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    pushExp("ovf_err", M_ALL, 1'b1, 8'd32, 6'd32, 1'b1);

    // Alloc and free together at full: 50 lands after register 63.
    resetDut("rst_swap");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd50, 1'b0);
    pushExp("full_swap", M_ALL, 1'b1, 8'd32, 6'd32, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      pushExp("swap_drain", M_ALL, 1'b1, (k == 32) ? 8'd50 : 8'(32 + k), 6'(33 - k), 1'b0);
    end

    // Allocate five, commit two, flush back to the architectural head.
    resetDut("rst_flush");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      pushExp("alloc5", M_ALL, 1'b1, 8'(32 + i), 6'(32 - i), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      pushExp("commit2", M_ALL, 1'b1, 8'd37, 6'd27, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    pushExp("flush", M_V | M_C | M_E, 1'b0, 8'd0, 6'd27, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    pushExp("flush_restore", M_ALL, 1'b1, 8'd34, 6'd30, 1'b0);

    // Flush together with commit, free of 33 and an allocation request.
    // head=4 and arch_head=2 going in. After the flush, head=arch_head=3
    // and tail=33, so the head shows mem[3]=35.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    pushExp("pre_mix0", M_ALL, 1'b1, 8'd34, 6'd30, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    pushExp("pre_mix1", M_ALL, 1'b1, 8'd35, 6'd29, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd33, 1'b1);
    pushExp("flush_mix", M_V | M_C | M_E, 1'b0, 8'd0, 6'd28, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    pushExp("flush_mix_after", M_ALL, 1'b1, 8'd35, 6'd30, 1'b0);

    // Commit with nothing allocated: refused and flagged.
    resetDut("rst_overrun");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    pushExp("overrun_cycle", M_ALL, 1'b1, 8'd32, 6'd32, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    pushExp("overrun_err", M_ALL, 1'b1, 8'd32, 6'd32, 1'b1);

    // Let the monitor drain the scoreboard, bounded.
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout pending=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical register IDs for the out-of-order core's rename stage. Rename dequeues one register per cycle for each instruction that writes a destination. ROB commit enqueues the superseded register (`coming_free_reg`). A second, architectural head pointer advances only on commit, so a pipeline flush returns every speculatively allocated register in one cycle.

## Interface
Parameters:
- `NUM_ARCH`, default 32: architectural registers. Physical regs `0..NUM_ARCH-1` are never in the list at reset.
- `NUM_PHYS`, default 64: physical registers.
- `DEPTH`, derived as `NUM_PHYS-NUM_ARCH` (32). Must be a power of two.
- `PW`, derived as `$clog2(DEPTH)+1`: pointer width including the wrap bit.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `alloc_req` in 1: rename requests one register this cycle.
- `alloc_valid` out 1: list is non-empty and not flushing.
- `alloc_preg` out 8 (`free_list_t`): register at the speculative head.
- `commit_valid` in 1: a committing instruction had allocated a register. Advances the architectural head.
- `free_valid` in 1: the committing instruction frees a register.
- `free_preg` in 8 (`free_list_t`): register being freed (the ROB's `coming_free_reg`).
- `flush` in 1: mispredict or exception recovery.
- `free_count` out PW: number of entries, `tail - head`.
- `err` out 1: sticky flag for overflow or architectural-head overrun.

## Operation
- Storage is `mem[DEPTH]` of `free_list_t`, plus PW-bit pointers `head`, `arch_head` and `tail`. The index is the low bits; the MSB is the wrap bit.
- `alloc_preg = mem[head[PW-2:0]]`. This read is combinational, first-word-fall-through.
- `alloc_valid = (free_count != 0) && !flush`.
- An allocation fires when `alloc_req && alloc_valid`. Then `head <= head+1`.
- `alloc_req` while `!alloc_valid` is ignored with no error. Rename must stall.
- A free fires when `free_valid` and the list is not full, or an allocation fires in the same cycle. Then `mem[tail] <= free_preg` and `tail <= tail+1`.
- `free_valid` while full with no allocation that cycle: the write is dropped and `err` is set.
- `commit_valid`: `arch_head <= arch_head+1`. If `arch_head == head` before the increment (commit of an unallocated register), set `err` and do not advance.
- `flush`:
  - Commit and free in the same cycle are applied first.
  - Then `head <= arch_head` (post-commit value).
  - Any allocation that cycle is suppressed.
- There is no read-write bypass. A register freed while the list is empty appears on `alloc_preg` the following cycle.
- Full is `tail - head == DEPTH`. Empty is `tail == head`. Pointer arithmetic is modulo 2^PW.
- No register ID is checked for duplicates. Uniqueness is the ROB's responsibility.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `mem[i] = NUM_ARCH+i`.
  - `head = arch_head = 0`.
  - `tail = DEPTH` (wrap bit 1, index 0).
  - `err = 0`.
- Outputs during reset: `free_count = DEPTH`, `alloc_valid = 1`, `alloc_preg = NUM_ARCH` (32).
- Allocation latency is 0 cycles, since data is presented before the request. The head advances at the clock edge.
- Free-to-visible latency is 1 cycle.
- `free_count` and `alloc_valid` reflect registered state only, plus the combinational `flush` mask on `alloc_valid`.
- Simultaneous alloc and free: both always proceed, including at full and at count 1. At empty the free proceeds and the alloc is blocked.
- Flush takes effect in 1 cycle. `alloc_valid` is reevaluated from the restored head the next cycle.
- Reset mid-operation discards all state and restores the reset image.

## Structure
- Add to the `rv32i_types` package:
  - `FREE_LIST_DEPTH` localparam.
  - A `free_list_ptr_t` typedef (PW bits).
- Reuse the existing `free_list_t`.
- No sub-module. Storage is a flop array, not SRAM, because of the asynchronous reset image and the combinational head read.

## Test plan
- Reset, then hold `alloc_req` for 32 cycles:
  - `alloc_preg` steps 32, 33, …, 63.
  - `alloc_valid` drops on cycle 33 with `free_count = 0`.
  - `err = 0`.
- From empty, pulse `free_valid` with `free_preg = 40` while `alloc_req = 1`:
  - No allocation that cycle.
  - Next cycle `alloc_valid = 1`, `alloc_preg = 40`, `free_count = 1`.
- After reset (full), `free_valid` with 50 and no alloc: `err = 1`, `free_count` stays 32, `alloc_preg` stays 32.
- After reset (full), alloc and free of 50 in the same cycle: `free_count` stays 32, `err = 0`, and 50 is allocated after register 63.
- Allocate 5 (32–36), commit 2, then `flush`: next cycle `alloc_preg = 34`, `free_count = 30`.
- Flush in the same cycle as `commit_valid` and `free_valid` with 33: the head is restored to the post-commit `arch_head`, the free is enqueued, and the allocation that cycle is suppressed.
